// File: rtl/mem_uart_bridge.sv
// mem_uart_bridge: turns MEM-stage loads/stores into RAM1 cycles or UART
// register accesses over the shared RAM1/UART data bus, stalling the
// pipeline until the access completes.
// Optional build macro: UART_WRITE_WAIT_EN -- after a UART write, hold the
// stall in UART_WAIT until the transmitter is empty (tbre & tsre).
module mem_uart_bridge #(
   parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
   parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   input  logic        mem_rd,
   input  logic        mem_wr,
   output logic [15:0] mem_rdata,
   output logic        mem_stall,
   output logic [17:0] ram1_addr,
   output logic [15:0] ram1_dout,
   input  logic [15:0] ram1_din,
   output logic        ram1_data_oe,
   output logic        ram1_en_n,
   output logic        ram1_oe_n,
   output logic        ram1_we_n,
   output logic        rdn,
   output logic        wrn,
   input  logic        data_ready,
   input  logic        tbre,
   input  logic        tsre
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_RAM_RD    = 4'd1;
   localparam logic [3:0] S_RAM_WR1   = 4'd2;
   localparam logic [3:0] S_RAM_WR2   = 4'd3;
   localparam logic [3:0] S_UART_RD1  = 4'd4;
   localparam logic [3:0] S_UART_RD2  = 4'd5;
   localparam logic [3:0] S_UART_WR1  = 4'd6;
   localparam logic [3:0] S_UART_WR2  = 4'd7;
   localparam logic [3:0] S_UART_WAIT = 4'd8;
   localparam logic [3:0] S_DONE      = 4'd9;

   logic [3:0]  state_q, state_d;
   logic [15:0] rdata_q, rdata_d;

   // Next-state decode and load-result capture.
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (mem_rd | mem_wr) begin
               // A simultaneous rd/wr is treated as a store throughout.
               if (mem_addr == UART_DATA_ADDR) begin
                  state_d = mem_wr ? S_UART_WR1 : S_UART_RD1;
               end else if (mem_addr == UART_STAT_ADDR) begin
                  // Status register is read-only; a store to it is dropped.
                  state_d = S_DONE;
                  if (!mem_wr) rdata_d = {14'b0, data_ready, tbre & tsre};
               end else begin
                  state_d = mem_wr ? S_RAM_WR1 : S_RAM_RD;
               end
            end
         end
         S_RAM_RD: begin
            rdata_d = ram1_din;
            state_d = S_DONE;
         end
         S_RAM_WR1:  state_d = S_RAM_WR2;
         S_RAM_WR2:  state_d = S_DONE;
         S_UART_RD1: state_d = S_UART_RD2;
         S_UART_RD2: begin
            rdata_d = {8'h00, ram1_din[7:0]};
            state_d = S_DONE;
         end
         S_UART_WR1: state_d = S_UART_WR2;
`ifdef UART_WRITE_WAIT_EN
         S_UART_WR2:  state_d = S_UART_WAIT;
         S_UART_WAIT: if (tbre & tsre) state_d = S_DONE;
`else
         S_UART_WR2:  state_d = S_DONE;
         S_UART_WAIT: state_d = S_IDLE;
`endif
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // State and load-result registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   // Bus strobes decoded purely from state so reset deasserts them at once.
   always_comb begin
      ram1_en_n    = 1'b1;
      ram1_oe_n    = 1'b1;
      ram1_we_n    = 1'b1;
      rdn          = 1'b1;
      wrn          = 1'b1;
      ram1_data_oe = 1'b0;
      ram1_dout    = 16'h0000;
      case (state_q)
         S_RAM_RD: begin
            ram1_en_n = 1'b0;
            ram1_oe_n = 1'b0;
         end
         S_RAM_WR1: begin
            ram1_en_n    = 1'b0;
            ram1_data_oe = 1'b1;
            ram1_dout    = mem_wdata;
         end
         S_RAM_WR2: begin
            ram1_en_n    = 1'b0;
            ram1_data_oe = 1'b1;
            ram1_dout    = mem_wdata;
            ram1_we_n    = 1'b0;
         end
         S_UART_RD1, S_UART_RD2: rdn = 1'b0;
         S_UART_WR1: begin
            ram1_data_oe = 1'b1;
            ram1_dout    = mem_wdata;
            wrn          = 1'b0;
         end
         S_UART_WR2: begin
            // wrn rises with data still on the bus to meet UART hold time.
            ram1_data_oe = 1'b1;
            ram1_dout    = mem_wdata;
         end
         default: ;
      endcase
   end

   assign mem_stall = (mem_rd | mem_wr) & (state_q != S_DONE);
   assign mem_rdata = rdata_q;
   assign ram1_addr = {2'b00, mem_addr};

endmodule
